// File: rtl/servo_pulse_decoder.sv
`default_nettype none
// ============================================================================
// Module   : servo_pulse_decoder
// Measures servo PWM frames: high time in TICK_DIV-clock ticks, frame period
// against FRAME_MAX. SERVO_DEC_FILTER_EN adds a 3-sample majority glitch filter.
// Revision : 1.0  initial release
// ============================================================================
module servo_pulse_decoder #(
    parameter int TICK_DIV  = 51,
    parameter int FRAME_MAX = 200000,
    parameter int CNT_W     = 21
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ena,
    input  logic       pwm_in,
    output logic [7:0] value,
    output logic       valid,
    output logic       overflow,
    output logic       timeout
);
    localparam int               DIV_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] FRAME_LIM = CNT_W'(FRAME_MAX);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_DIV - 1);
    localparam logic [8:0]       TICK_SAT  = 9'd511;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;
    logic lvl;

`ifdef SERVO_DEC_FILTER_EN
    logic hist1_q, hist1_d;
    logic hist2_q, hist2_d;
    logic filt_q,  filt_d;

    // Majority over three consecutive samples, registered: +2 clocks on both edges.
    always_comb begin
        hist1_d = sync2_q;
        hist2_d = hist1_q;
        filt_d  = (sync2_q & hist1_q) | (sync2_q & hist2_q) | (hist1_q & hist2_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hist1_q <= 1'b0;
            hist2_q <= 1'b0;
            filt_q  <= 1'b0;
        end else begin
            hist1_q <= hist1_d;
            hist2_q <= hist2_d;
            filt_q  <= filt_d;
        end
    end

    assign lvl = filt_q;
`else
    assign lvl = sync2_q;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [8:0]       hi_ticks_q, hi_ticks_d;
    logic [8:0]       width_q, width_d;
    logic [7:0]       value_q, value_d;
    logic             valid_q, valid_d;
    logic             overflow_q, overflow_d;
    logic             timeout_q, timeout_d;
    logic             rise, fall, frame_full;

    assign rise       = lvl & ~prev_q;
    assign fall       = ~lvl & prev_q;
    assign frame_full = (frame_cnt_q == FRAME_LIM);

    // Synchroniser and edge history run regardless of ena so stale edges are dropped.
    always_comb begin
        sync1_d = pwm_in;
        sync2_d = sync1_q;
        prev_d  = lvl;
    end

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        div_cnt_d   = div_cnt_q;
        hi_ticks_d  = hi_ticks_q;
        width_d     = width_q;
        value_d     = value_q;
        valid_d     = 1'b0;
        overflow_d  = overflow_q;
        timeout_d   = timeout_q;

        if (ena) begin
            if (rise) begin
                frame_cnt_d = '0;
            end else if (!frame_full) begin
                frame_cnt_d = frame_cnt_q + CNT_W'(1);
            end

            if (state_q == HIGH) begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    if (hi_ticks_q != TICK_SAT) begin
                        hi_ticks_d = hi_ticks_q + 9'd1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end

            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_d    = HIGH;
                        div_cnt_d  = '0;
                        hi_ticks_d = '0;
                    end
                end
                HIGH: begin
                    if (frame_full) begin
                        state_d   = IDLE;
                        timeout_d = 1'b1;
                    end else if (fall) begin
                        // Includes the tick earned on this last high clock.
                        state_d = LOW;
                        width_d = hi_ticks_d;
                    end
                end
                LOW: begin
                    if (rise) begin
                        state_d    = HIGH;
                        div_cnt_d  = '0;
                        hi_ticks_d = '0;
                        value_d    = width_q[8] ? 8'hFF : width_q[7:0];
                        overflow_d = width_q[8];
                        valid_d    = 1'b1;
                        timeout_d  = 1'b0;
                    end else if (frame_full) begin
                        state_d   = IDLE;
                        timeout_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            prev_q      <= 1'b0;
            state_q     <= IDLE;
            frame_cnt_q <= '0;
            div_cnt_q   <= '0;
            hi_ticks_q  <= '0;
            width_q     <= '0;
            value_q     <= '0;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            prev_q      <= prev_d;
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            div_cnt_q   <= div_cnt_d;
            hi_ticks_q  <= hi_ticks_d;
            width_q     <= width_d;
            value_q     <= value_d;
            valid_q     <= valid_d;
            overflow_q  <= overflow_d;
            timeout_q   <= timeout_d;
        end
    end

    assign value    = value_q;
    assign valid    = valid_q;
    assign overflow = overflow_q;
    assign timeout  = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_servo_pulse_decoder.sv
`default_nettype none
// Directed bench for servo_pulse_decoder with hand-computed expected values.
module tb_servo_pulse_decoder;
    localparam int TICK_DIV  = 51;
    localparam int FRAME_MAX = 16000;
`ifdef SERVO_DEC_FILTER_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 3;
`endif

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       ena    = 1'b1;
    logic       pwm_in = 1'b0;
    logic [7:0] value;
    logic       valid;
    logic       overflow;
    logic       timeout;

    int   n_checks   = 0;
    int   n_pass     = 0;
    int   cyc        = 0;
    int   vcnt       = 0;
    int   vwide      = 0;
    logic valid_prev = 1'b0;
    int   rcyc;
    int   saved;

    servo_pulse_decoder #(
        .TICK_DIV (TICK_DIV),
        .FRAME_MAX(FRAME_MAX),
        .CNT_W    (21)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .ena     (ena),
        .pwm_in  (pwm_in),
        .value   (value),
        .valid   (valid),
        .overflow(overflow),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid) vcnt <= vcnt + 1;
        if (valid && valid_prev) vwide <= vwide + 1;
        valid_prev <= valid;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int hi, input int lo);
        pwm_in = 1'b1;
        step(hi);
        pwm_in = 1'b0;
        step(lo);
    endtask

    initial begin
        step(3);
        check_eq("rst_value", int'(value), 0);
        check_eq("rst_valid", int'(valid), 0);
        check_eq("rst_overflow", int'(overflow), 0);
        check_eq("rst_timeout", int'(timeout), 0);
        reset = 1'b0;
        step(2);

        // Three rises: the first only arms, so two frames are published.
        pulse(5100, 200);
        pulse(5100, 200);
        pulse(5100, 200);
        check_eq("t1_valid_cnt", vcnt, 2);
        check_eq("t1_value", int'(value), 100);
        check_eq("t1_overflow", int'(overflow), 0);

        // 300 ticks saturates, then 2550 clocks gives 50.
        pulse(15300, 300);
        pwm_in = 1'b1;
        step(10);
        check_eq("t2_sat_value", int'(value), 255);
        check_eq("t2_sat_overflow", int'(overflow), 1);
        check_eq("t2_no_timeout", int'(timeout), 0);
        step(2540);
        pwm_in = 1'b0;
        step(200);
        pwm_in = 1'b1;
        rcyc = cyc;
        step(10);
        check_eq("t2_value50", int'(value), 50);
        check_eq("t2_overflow0", int'(overflow), 0);

        // Hold low: rise taken LAT clocks after the drive, timeout one clock after frame_cnt hits FRAME_MAX.
        step(5090);
        pwm_in = 1'b0;
        step(rcyc + FRAME_MAX + LAT - cyc);
        check_eq("t3_timeout_early", int'(timeout), 0);
        step(1);
        check_eq("t3_timeout_set", int'(timeout), 1);
        saved = vcnt;
        pulse(5100, 200);
        check_eq("t3_timeout_armed", int'(timeout), 1);
        check_eq("t3_arm_no_valid", vcnt, saved);
        pwm_in = 1'b1;
        step(10);
        check_eq("t3_timeout_clr", int'(timeout), 0);
        check_eq("t3_value", int'(value), 100);
        check_eq("t3_valid_cnt", vcnt, saved + 1);

        // Reset mid-high.
        step(2000);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check_eq("t4_value", int'(value), 0);
        check_eq("t4_overflow", int'(overflow), 0);
        check_eq("t4_timeout", int'(timeout), 0);
        check_eq("t4_valid", int'(valid), 0);
        saved = vcnt;
        step(3089);
        pwm_in = 1'b0;
        step(200);
        check_eq("t4_rise_no_valid", vcnt, saved);
        pulse(5100, 200);

        // One-clock low glitch 20 clocks into a 5100-clock high.
        pwm_in = 1'b1;
        step(20);
        pwm_in = 1'b0;
        step(1);
        pwm_in = 1'b1;
        step(10);
`ifndef SERVO_DEC_FILTER_EN
        check_eq("t5_glitch_trunc", int'(value), 0);
`endif
        step(5069);
        pwm_in = 1'b0;
        step(200);
        pwm_in = 1'b1;
        step(10);
`ifdef SERVO_DEC_FILTER_EN
        check_eq("t5_filtered", int'(value), 100);
`else
        check_eq("t5_remainder", int'(value), 99);
`endif

        // 5100-clock high with ena low for 1000 of them: 4100/51 = 80.
        step(1000);
        ena = 1'b0;
        step(1000);
        ena = 1'b1;
        step(3090);
        pwm_in = 1'b0;
        step(200);
        pwm_in = 1'b1;
        step(10);
        check_eq("t6_ena_value", int'(value), 80);
        check_eq("t6_ena_overflow", int'(overflow), 0);

        check_eq("valid_one_clk", vwide, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
